// File: rtl/modn_down_count_ctrl.sv
// Modulo-N down counter controller: loads a start value through a valid/ready
// handshake, counts down with reload, and stops after a set number of wraps.
module modn_down_count_ctrl #(
  parameter int W  = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [W-1:0]  cfg_top,
  input  logic [CW-1:0] cfg_cycles,
  input  logic          pause,
  input  logic          abort,
  output logic [W-1:0]  cnt,
  output logic          tc,
  output logic [CW-1:0] wrap_cnt,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  cnt_nxt, top_q, top_nxt;
  logic [CW-1:0] wrap_nxt, cycles_q, cycles_nxt;
  logic          err_nxt;
  logic          last_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      wrap_cnt <= '0;
      top_q    <= '0;
      cycles_q <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wrap_cnt <= wrap_nxt;
      top_q    <= top_nxt;
      cycles_q <= cycles_nxt;
      err      <= err_nxt;
    end
  end

  // A bounded run ends on the terminal count of its final wrap.
  assign last_wrap = (cycles_q != '0) && (wrap_cnt == cycles_q - CW'(1));

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    wrap_nxt   = wrap_cnt;
    top_nxt    = top_q;
    cycles_nxt = cycles_q;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_top == '0) begin
            err_nxt = 1'b1;
          end else begin
            top_nxt    = cfg_top;
            cycles_nxt = cfg_cycles;
            cnt_nxt    = cfg_top;
            wrap_nxt   = '0;
            state_nxt  = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (pause) begin
          state_nxt = PAUSE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - W'(1);
        end else if (last_wrap) begin
          wrap_nxt  = cycles_q;
          state_nxt = DONE;
        end else begin
          cnt_nxt  = top_q;
          wrap_nxt = wrap_cnt + CW'(1);
        end
      end
      PAUSE: begin
        if (abort) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (!pause) begin
          state_nxt = RUN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN) || (state == PAUSE);
  assign done      = (state == DONE);
  assign tc        = (state == RUN) && (cnt == '0);

endmodule

// File: tb/tb_modn_down_count_ctrl.sv
// Self-checking bench for modn_down_count_ctrl: directed vector table, reset
// and free-run sequences, then random traffic against a behavioural model.
module tb_modn_down_count_ctrl;

  localparam int W  = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [W-1:0]  cfg_top;
  logic [CW-1:0] cfg_cycles;
  logic          pause;
  logic          abort;
  logic [W-1:0]  cnt;
  logic          tc;
  logic [CW-1:0] wrap_cnt;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int passed = 0;

  modn_down_count_ctrl #(.W(W), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_top    (cfg_top),
    .cfg_cycles (cfg_cycles),
    .pause      (pause),
    .abort      (abort),
    .cnt        (cnt),
    .tc         (tc),
    .wrap_cnt   (wrap_cnt),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Behavioural model: a run is "active" (counting or held), "finishing" marks
  // the single completion cycle, and the count is plain integer arithmetic.
  bit m_active, m_held, m_finishing, m_err;
  int m_cnt, m_wrap, m_top, m_cyc;

  task automatic modelReset();
    m_active = 0; m_held = 0; m_finishing = 0; m_err = 0;
    m_cnt = 0; m_wrap = 0; m_top = 0; m_cyc = 0;
  endtask

  task automatic modelStep(input bit v, input int top, input int cyc, input bit p, input bit a);
    bit new_err = 0;
    int completed;
    if (m_finishing) begin
      m_finishing = 0;
    end else if (!m_active) begin
      if (v) begin
        if (top == 0) new_err = 1;
        else begin
          m_top = top; m_cyc = cyc; m_active = 1; m_held = 0;
          m_cnt = top; m_wrap = 0;
        end
      end
    end else if (a) begin
      m_active = 0; m_held = 0; m_cnt = 0;
    end else if (m_held) begin
      if (!p) m_held = 0;
    end else if (p) begin
      m_held = 1;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
    end else begin
      completed = m_wrap + 1;
      if (m_cyc != 0 && completed == m_cyc) begin
        m_active = 0; m_finishing = 1; m_wrap = m_cyc;
      end else begin
        m_cnt = m_top; m_wrap = completed % (1 << CW);
      end
    end
    m_err = new_err;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_cnt"},   cnt,       m_cnt);
    checkOutput({tag, "_tc"},    tc,        int'(m_active && !m_held && m_cnt == 0));
    checkOutput({tag, "_wrap"},  wrap_cnt,  m_wrap);
    checkOutput({tag, "_busy"},  busy,      int'(m_active));
    checkOutput({tag, "_done"},  done,      int'(m_finishing));
    checkOutput({tag, "_err"},   err,       int'(m_err));
    checkOutput({tag, "_ready"}, cfg_ready, int'(!m_active && !m_finishing));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cnt"},   cnt,       0);
    checkOutput({tag, "_tc"},    tc,        0);
    checkOutput({tag, "_wrap"},  wrap_cnt,  0);
    checkOutput({tag, "_busy"},  busy,      0);
    checkOutput({tag, "_done"},  done,      0);
    checkOutput({tag, "_err"},   err,       0);
    checkOutput({tag, "_ready"}, cfg_ready, 1);
  endtask

  // Drives one cycle of inputs, advances the model, and settles past the edge.
  task automatic applyStimulus(input bit v, input int top, input int cyc, input bit p, input bit a);
    cfg_valid  = v;
    cfg_top    = W'(top);
    cfg_cycles = CW'(cyc);
    pause      = p;
    abort      = a;
    modelStep(v, top, cyc, p, a);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit v; int top; int cyc; bit p; bit a;
    int cnt; bit tc; int wrap; bit busy; bit done; bit err; bit rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic addVec(input bit v, input int top, input int cyc, input bit p, input bit a,
                        input int c, input bit t, input int w, input bit b, input bit d,
                        input bit e, input bit r);
    vec_t x;
    x.v = v; x.top = top; x.cyc = cyc; x.p = p; x.a = a;
    x.cnt = c; x.tc = t; x.wrap = w; x.busy = b; x.done = d; x.err = e; x.rdy = r;
    tbl.push_back(x);
  endtask

  initial begin
    bit seen_roll;
    bit seen_done;
    int prev_wrap;

    // top=5, two wraps, then done and back to idle
    addVec(1,5,2,0,0, 5,0,0,1,0,0,0);
    addVec(0,0,0,0,0, 4,0,0,1,0,0,0);
    addVec(0,0,0,0,0, 3,0,0,1,0,0,0);
    addVec(0,0,0,0,0, 2,0,0,1,0,0,0);
    addVec(0,0,0,0,0, 1,0,0,1,0,0,0);
    addVec(0,0,0,0,0, 0,1,0,1,0,0,0);
    addVec(0,0,0,0,0, 5,0,1,1,0,0,0);
    addVec(0,0,0,0,0, 4,0,1,1,0,0,0);
    addVec(0,0,0,0,0, 3,0,1,1,0,0,0);
    addVec(0,0,0,0,0, 2,0,1,1,0,0,0);
    addVec(0,0,0,0,0, 1,0,1,1,0,0,0);
    addVec(0,0,0,0,0, 0,1,1,1,0,0,0);
    addVec(0,0,0,0,0, 0,0,2,0,1,0,0);
    addVec(0,0,0,0,0, 0,0,2,0,0,0,1);
    // rejected zero-top handshake
    addVec(1,0,3,0,0, 0,0,2,0,0,1,1);
    addVec(0,0,0,0,0, 0,0,2,0,0,0,1);
    // free run, config offered while busy is ignored, pause at cnt=3
    addVec(1,5,0,0,0, 5,0,0,1,0,0,0);
    addVec(1,2,1,0,0, 4,0,0,1,0,0,0);
    addVec(0,0,0,0,0, 3,0,0,1,0,0,0);
    addVec(0,0,0,1,0, 3,0,0,1,0,0,0);
    addVec(0,0,0,1,0, 3,0,0,1,0,0,0);
    addVec(0,0,0,1,0, 3,0,0,1,0,0,0);
    addVec(0,0,0,0,0, 3,0,0,1,0,0,0);
    addVec(0,0,0,0,0, 2,0,0,1,0,0,0);
    addVec(0,0,0,0,0, 1,0,0,1,0,0,0);
    addVec(0,0,0,0,0, 0,1,0,1,0,0,0);
    addVec(0,0,0,0,0, 5,0,1,1,0,0,0);
    addVec(0,0,0,0,0, 4,0,1,1,0,0,0);
    // pause at cnt=4, then abort while paused
    addVec(0,0,0,1,0, 4,0,1,1,0,0,0);
    addVec(0,0,0,1,1, 0,0,1,0,0,0,1);
    addVec(0,0,0,1,1, 0,0,1,0,0,0,1);

    rst_n = 1'b0; cfg_valid = 0; cfg_top = '0; cfg_cycles = '0; pause = 0; abort = 0;
    modelReset();
    #12;
    checkResetValues("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].v, tbl[i].top, tbl[i].cyc, tbl[i].p, tbl[i].a);
      checkOutput($sformatf("tbl%0d_cnt", i),   cnt,       tbl[i].cnt);
      checkOutput($sformatf("tbl%0d_tc", i),    tc,        tbl[i].tc);
      checkOutput($sformatf("tbl%0d_wrap", i),  wrap_cnt,  tbl[i].wrap);
      checkOutput($sformatf("tbl%0d_busy", i),  busy,      tbl[i].busy);
      checkOutput($sformatf("tbl%0d_done", i),  done,      tbl[i].done);
      checkOutput($sformatf("tbl%0d_err", i),   err,       tbl[i].err);
      checkOutput($sformatf("tbl%0d_ready", i), cfg_ready, tbl[i].rdy);
    end

    // asynchronous reset in the middle of a run at cnt=2
    applyStimulus(1, 5, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pre_reset_cnt", cnt, 2);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkResetValues("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkModel("post_reset");

    // free-running top=1: wrap counter rolls over, done stays low
    applyStimulus(1, 1, 0, 0, 0);
    checkModel("freerun_start");
    seen_roll = 0;
    seen_done = 0;
    for (int i = 0; i < 520; i++) begin
      prev_wrap = wrap_cnt;
      applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 0, 0);
      if (done) seen_done = 1;
      if (prev_wrap == 255 && wrap_cnt == 0) seen_roll = 1;
      if (i % 64 == 0) checkModel($sformatf("freerun%0d", i));
    end
    checkModel("freerun_end");
    checkOutput("freerun_rollover", seen_roll, 1);
    checkOutput("freerun_no_done", seen_done, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkModel("freerun_abort");

    // random traffic against the model
    for (int i = 0; i < 1200; i++) begin
      applyStimulus(bit'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 4) == 0),
                    bit'($urandom_range(0, 28) == 0));
      checkModel($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/modn_down_count_ctrl.md
MODN_DOWN_COUNT_CTRL -- requirements
Module: modn_down_count_ctrl

Interface
REQ-001 SHALL have parameter W, default 3, counter width in bits.
REQ-002 SHALL have parameter CW, default 8, wrap-count width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_valid  input  1  configuration offered.
REQ-006 SHALL have port cfg_ready  output  1  controller accepts configuration; high only in IDLE.
REQ-007 SHALL have port cfg_top  input  W  start value of the down count; modulus = cfg_top+1.
REQ-008 SHALL have port cfg_cycles  input  CW  number of full wraps to run; 0 = free-run.
REQ-009 SHALL have port pause  input  1  hold count while high.
REQ-010 SHALL have port abort  input  1  synchronous stop request.
REQ-011 SHALL have port cnt  output  W  current count value.
REQ-012 SHALL have port tc  output  1  terminal count; combinational, high when state==RUN and cnt==0.
REQ-013 SHALL have port wrap_cnt  output  CW  completed wraps in the current run.
REQ-014 SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at run completion.
REQ-016 SHALL have port err  output  1  one-cycle pulse on rejected configuration.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, PAUSE, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-018 SHALL accept configuration on cfg_valid&&cfg_ready; it SHALL latch cfg_top/cfg_cycles internally and ignore cfg_* at all other times.
REQ-019 SHALL reject a handshake with cfg_top==0: err=1 next cycle for one cycle, state stays IDLE, cnt/wrap_cnt unchanged.
REQ-020 SHALL, on an accepted valid handshake in cycle c, enter RUN with cnt=top and wrap_cnt=0 at cycle c+1.
REQ-021 SHALL, in RUN with pause=0 and abort=0, decrement cnt by 1 per cycle when cnt!=0.
REQ-022 SHALL, in RUN at cnt==0 (tc=1), reload cnt=top and increment wrap_cnt (modulo 2^CW) on the next edge.
REQ-023 SHALL, when cycles!=0 and the tc cycle completes wrap number cycles, go to DONE instead: cnt stays 0, wrap_cnt=cycles, done=1 during DONE.
REQ-024 SHALL never assert done when cycles==0; wrap_cnt wraps 2^CW-1 -> 0 silently.
REQ-025 SHALL, in RUN with pause=1, hold cnt and wrap_cnt and enter PAUSE; tc SHALL NOT count a wrap that cycle.
REQ-026 SHALL hold cnt and wrap_cnt in PAUSE; pause=0 in PAUSE returns to RUN with cnt held that cycle; decrement resumes the following cycle.
REQ-027 SHALL, on abort=1 in RUN or PAUSE, go to IDLE next cycle with cnt=0, wrap_cnt held, no done; abort has priority over pause and tc.
REQ-028 SHALL ignore abort and pause in IDLE and DONE.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state=IDLE, cnt=0, wrap_cnt=0, done=0, err=0, busy=0, tc=0, latched config=0; cfg_ready=1 once rst_n=0 asserted.
REQ-030 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; reset mid-run discards the run with no done.

Verification
REQ-031 SHALL cover: top=5, cycles=2 -> cnt 5,4,3,2,1,0,5,4,3,2,1,0; tc at both 0s; wrap_cnt 0->1->2; done one cycle after second 0; then cfg_ready=1.
REQ-032 SHALL cover: top=0 handshake -> err one-cycle pulse, busy=0, cfg_ready stays 1.
REQ-033 SHALL cover: top=5, pause high 3 cycles starting at cnt=3 -> cnt=3 for 4 cycles, then 2.
REQ-034 SHALL cover: abort during PAUSE at cnt=4 -> IDLE next cycle, cnt=0, done never asserted.
REQ-035 SHALL cover: rst_n low asynchronously mid-RUN at cnt=2 -> all outputs at reset values before next edge.
REQ-036 SHALL cover: top=1, cycles=0, 520 RUN cycles -> wrap_cnt wraps 255->0, done never asserted; cfg_valid while busy ignored.
